mem_access_seq: RTL

- Sequences the data-memory port for the core's load/store stage.
- Accepts one request at a time and issues reads and writes to a word-only synchronous RAM, which has no byte enables.
- Byte stores are performed as a read-modify-write.
- Byte loads return the addressed byte in its own lane with all other bits zero; this is the existing byte-lane load convention. Word loads and stores pass through unchanged.

---
 rtl/mem_access_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// Load/store sequencer for a word-only synchronous RAM: byte stores via read-modify-write, byte loads lane-aligned.
// Optional macro MISALIGN_TRAP_EN: word accesses with a nonzero byte offset respond at once with Resp_Err=1.
module mem_access_seq #(
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic              Req_Byte,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [31:0]       Req_WData,
  output logic              Resp_Valid,
  output logic [31:0]       Resp_RData,
  output logic              Resp_Err,
  output logic              Busy,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-3:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t      state, next_state;
  logic [2:0]  lat_cnt;
  logic        write_q;
  logic        byte_q;
  logic [1:0]  off_q;
  logic [7:0]  wbyte_q;
  logic        accept;
  logic        misalign;
  logic        last_wait;
  logic [31:0] load_data;

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off);
    lane_extract = word & (32'h0000_00FF << {off, 3'b000});
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [7:0] b,
                                             input logic [1:0] off);
    lane_merge = (word & ~(32'h0000_00FF << {off, 3'b000})) | ({24'h0, b} << {off, 3'b000});
  endfunction

  assign Req_Ready = (state == IDLE);
  assign Busy      = (state != IDLE);
  assign accept    = Req_Valid && (state == IDLE);
  assign last_wait = (state == WAIT) && (lat_cnt == 3'd1);
  assign load_data = byte_q ? lane_extract(Mem_RData, off_q) : Mem_RData;

`ifdef MISALIGN_TRAP_EN
  assign misalign = !Req_Byte && (Req_Addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misalign)                   next_state = RESP;
          else if (Req_Write && !Req_Byte) next_state = WR;
          else                            next_state = RD;
        end
      end
      RD:   next_state = WAIT;
      WAIT: if (lat_cnt == 3'd1) next_state = write_q ? WR : RESP;
      WR:   next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so each strobe lines up with its state cycle
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      off_q      <= 2'b00;
      wbyte_q    <= 8'h00;
      Mem_En     <= 1'b0;
      Mem_We     <= 1'b0;
      Mem_Addr   <= '0;
      Mem_WData  <= '0;
      Resp_Valid <= 1'b0;
      Resp_RData <= '0;
      Resp_Err   <= 1'b0;
    end else begin
      state      <= next_state;
      Mem_En     <= (next_state == RD) || (next_state == WR);
      Mem_We     <= (next_state == WR);
      Resp_Valid <= (next_state == RESP);
      Resp_Err   <= accept && misalign;
      Resp_RData <= (last_wait && !write_q) ? load_data : 32'h0;
      if (accept) begin
        write_q  <= Req_Write;
        byte_q   <= Req_Byte;
        off_q    <= Req_Addr[1:0];
        wbyte_q  <= Req_WData[7:0];
        Mem_Addr <= Req_Addr[ADDR_W-1:2];
      end
      if (state == RD)        lat_cnt <= 3'(READ_LAT);
      else if (state == WAIT) lat_cnt <= lat_cnt - 3'd1;
      // Word stores write the request data directly; byte stores write the merged read word
      if (next_state == WR)
        Mem_WData <= (state == WAIT) ? lane_merge(Mem_RData, wbyte_q, off_q) : Req_WData;
    end
  end

endmodule
